time_set_ctrl: RTL and testbench

//  Time-setting controller for the real-time clock. Sequences the shared load/addrs/data_in bus
//  of the seconds, minutes and hours counters from two debounced buttons. Walks through fields

---
 rtl/time_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - RTC time-setting controller (optional feature macro: AUTO_REPEAT_EN)
module time_set_ctrl #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int HOUR_MAX      = 23,
  parameter int MINSEC_MAX    = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tc_time_base,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] q_seconds,
  input  logic [5:0] q_minutes,
  input  logic [5:0] q_hours,
  output logic       load,
  output logic [1:0] addrs,
  output logic [5:0] data_in,
  output logic       run_en,
  output logic [1:0] edit_field
);

  typedef enum logic [1:0] {
    S_RUN,
    S_EDIT_HR,
    S_EDIT_MIN,
    S_EDIT_SEC
  } state_t;

  localparam int              TW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [5:0]      HR_MAX6 = 6'(HOUR_MAX);
  localparam logic [5:0]      MS_MAX6 = 6'(MINSEC_MAX);

  state_t        state_q, state_n;
  logic [5:0]    edit_val_q, edit_val_n;
  logic [TW-1:0] to_cnt_q, to_cnt_n;
  logic          mode_q, inc_q;
  logic          load_n;
  logic [1:0]    addrs_n;
  logic [5:0]    data_n;
  logic          run_en_n;
  logic [1:0]    field_n;
  logic          mode_rise, inc_rise;
  logic          bump;
  logic [5:0]    field_max;

  // Field code shared by addrs and edit_field; 11 marks "not editing".
  function automatic logic [1:0] field_code(input state_t s);
    case (s)
      S_EDIT_HR:  field_code = 2'b10;
      S_EDIT_MIN: field_code = 2'b01;
      S_EDIT_SEC: field_code = 2'b00;
      default:    field_code = 2'b11;
    endcase
  endfunction

  assign mode_rise = btn_mode & ~mode_q;
  assign inc_rise  = btn_inc & ~inc_q;

  // State, edit value, timeout counter, edge history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      edit_val_q <= '0;
      to_cnt_q   <= '0;
      mode_q     <= 1'b0;
      inc_q      <= 1'b0;
      load       <= 1'b0;
      addrs      <= 2'b00;
      data_in    <= '0;
      run_en     <= 1'b1;
      edit_field <= 2'b11;
    end else begin
      state_q    <= state_n;
      edit_val_q <= edit_val_n;
      to_cnt_q   <= to_cnt_n;
      mode_q     <= btn_mode;
      inc_q      <= btn_inc;
      load       <= load_n;
      addrs      <= addrs_n;
      data_in    <= data_n;
      run_en     <= run_en_n;
      edit_field <= field_n;
    end
  end

  // Next-state and next-output logic; mode edges take priority over increments.
  always_comb begin
    state_n    = state_q;
    edit_val_n = edit_val_q;
    to_cnt_n   = to_cnt_q;
    load_n     = 1'b0;
    addrs_n    = addrs;
    data_n     = data_in;
    bump       = 1'b0;
    field_max  = (state_q == S_EDIT_HR) ? HR_MAX6 : MS_MAX6;

    case (state_q)
      S_RUN: begin
        to_cnt_n = '0;
        if (mode_rise) begin
          state_n    = S_EDIT_HR;
          edit_val_n = q_hours;
        end
      end
      default: begin
        if (mode_rise) begin
          // Commit the current field and capture the next one.
          load_n   = 1'b1;
          addrs_n  = field_code(state_q);
          data_n   = edit_val_q;
          to_cnt_n = '0;
          case (state_q)
            S_EDIT_HR: begin
              state_n    = S_EDIT_MIN;
              edit_val_n = q_minutes;
            end
            S_EDIT_MIN: begin
              state_n    = S_EDIT_SEC;
              edit_val_n = q_seconds;
            end
            default: state_n = S_RUN;
          endcase
        end else begin
          bump = inc_rise;
`ifdef AUTO_REPEAT_EN
          // A held button steps once per time-base tick, without refreshing the timeout.
          bump = bump | (btn_inc & inc_q & tc_time_base);
`endif
          if (bump) begin
            // Values captured above the limit also wrap straight to zero.
            edit_val_n = (edit_val_q >= field_max) ? 6'd0 : edit_val_q + 6'd1;
          end
          if (inc_rise) begin
            to_cnt_n = '0;
          end else if (tc_time_base) begin
            if (to_cnt_q == TO_LAST) begin
              // Abandon editing: the current field is dropped, earlier loads stand.
              state_n  = S_RUN;
              to_cnt_n = '0;
            end else begin
              to_cnt_n = to_cnt_q + TW'(1);
            end
          end
        end
      end
    endcase

    run_en_n = (state_n == S_RUN);
    field_n  = field_code(state_n);
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tc_time_base;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] q_seconds;
  logic [5:0] q_minutes;
  logic [5:0] q_hours;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic       run_en;
  logic [1:0] edit_field;

  int tests = 0;
  int fails = 0;

  // Reference model: idx -1 = running, 0/1/2 = hours/minutes/seconds being edited.
  int fcode[3] = '{2, 1, 0};
  int fmax[3]  = '{23, 59, 59};
  int m_idx, m_val, m_to, m_pm, m_pi;
  int e_load, e_addrs, e_data, e_run, e_field;

  time_set_ctrl dut (
    .clk(clk),
    .reset(reset),
    .tc_time_base(tc_time_base),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .q_seconds(q_seconds),
    .q_minutes(q_minutes),
    .q_hours(q_hours),
    .load(load),
    .addrs(addrs),
    .data_in(data_in),
    .run_en(run_en),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = -1; m_val = 0; m_to = 0; m_pm = 0; m_pi = 0;
    e_load = 0; e_addrs = 0; e_data = 0; e_run = 1; e_field = 3;
  endtask

  // One clock of the specified behaviour, from the levels presented this cycle.
  task automatic model_clock(input int m, input int i, input int t);
    int mr, ir, bump;
    mr = (m == 1 && m_pm == 0);
    ir = (i == 1 && m_pi == 0);
    m_pm = m;
    m_pi = i;
    e_load = 0;
    if (m_idx < 0) begin
      if (mr) begin
        m_idx = 0; m_val = q_hours; m_to = 0;
      end
    end else if (mr) begin
      e_load = 1; e_addrs = fcode[m_idx]; e_data = m_val; m_to = 0;
      m_idx = m_idx + 1;
      if (m_idx == 3) m_idx = -1;
      else m_val = (m_idx == 1) ? q_minutes : q_seconds;
    end else begin
      bump = ir;
`ifdef AUTO_REPEAT_EN
      if (i == 1 && !ir && t == 1) bump = 1;
`endif
      if (bump) m_val = (m_val >= fmax[m_idx]) ? 0 : m_val + 1;
      if (ir) m_to = 0;
      else if (t) begin
        m_to = m_to + 1;
        if (m_to >= 30) begin
          m_idx = -1; m_to = 0;
        end
      end
    end
    e_run   = (m_idx < 0);
    e_field = (m_idx < 0) ? 3 : fcode[m_idx];
  endtask

  task automatic step(input logic m, input logic i, input logic t);
    btn_mode = m; btn_inc = i; tc_time_base = t;
    model_clock(int'(m), int'(i), int'(t));
    @(posedge clk);
    #1;
    chk("load", load, e_load);
    chk("addrs", addrs, e_addrs);
    chk("data_in", data_in, e_data);
    chk("run_en", run_en, e_run);
    chk("edit_field", edit_field, e_field);
    tc_time_base = 1'b0;
  endtask

  int exp6;
  logic rm, ri;

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tc_time_base = 1'b0;
    q_seconds = 6'd20; q_minutes = 6'd10; q_hours = 6'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", load, 0);
    chk("rst_addrs", addrs, 0);
    chk("rst_data", data_in, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_field", edit_field, 3);
    reset = 1'b1;
    step(0, 0, 0);

    // Full edit walk: loads (10,7), (01,10), (00,21).
    step(0, 1, 0); step(0, 0, 0);
    chk("t1_inc_in_run", edit_field, 3);
    step(1, 0, 0); chk("t1_enter_run_en", run_en, 0); chk("t1_enter_field", edit_field, 2);
    step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0);
    chk("t1_hr_load", load, 1); chk("t1_hr_addr", addrs, 2); chk("t1_hr_data", data_in, 7);
    step(0, 0, 0); chk("t1_load_one_cycle", load, 0); chk("t1_hold_data", data_in, 7);
    step(1, 0, 0);
    chk("t1_min_addr", addrs, 1); chk("t1_min_data", data_in, 10);
    step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0);
    chk("t1_sec_load", load, 1); chk("t1_sec_addr", addrs, 0); chk("t1_sec_data", data_in, 21);
    chk("t1_run_with_sec_load", run_en, 1); chk("t1_field_run", edit_field, 3);
    step(0, 0, 0);

    // Wrap at hour and minute limits, and a captured out-of-range hour.
    q_hours = 6'd23; q_minutes = 6'd59; q_seconds = 6'd3;
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0); chk("t2_hr_wrap", data_in, 0); chk("t2_hr_addr", addrs, 2);
    step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0); chk("t2_min_wrap", data_in, 0); chk("t2_min_addr", addrs, 1);
    step(0, 0, 0);
    step(1, 0, 0); chk("t2_sec_keep", data_in, 3);
    step(0, 0, 0);
    q_hours = 6'd30;
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0); chk("t2_over_max_wrap", data_in, 0);
    step(0, 0, 0);

    // Timeout in minutes field: no minutes load, back to running.
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 1);
      if (k == 29) chk("t3_still_editing", edit_field, 1);
      step(0, 0, 0);
    end
    chk("t3_timeout_run_en", run_en, 1);
    chk("t3_timeout_field", edit_field, 3);
    chk("t3_no_min_load", addrs, 2);

    // Mode and inc rising together: mode wins.
    q_hours = 6'd4;
    step(1, 0, 0); step(0, 0, 0);
    step(1, 1, 0);
    chk("t4_load", load, 1); chk("t4_addr", addrs, 2); chk("t4_data", data_in, 4);
    chk("t4_field", edit_field, 1);
    step(0, 0, 0);

    // Asynchronous reset in the middle of seconds edit.
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_load", load, 0); chk("t5_run_en", run_en, 1); chk("t5_field", edit_field, 3);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 1, 0); step(0, 0, 0);
    chk("t5_stay_run", edit_field, 3);
    q_hours = 6'd1;
    step(1, 0, 0); chk("t5_reenter", edit_field, 2);
    step(0, 0, 0);

    // Held inc across five ticks in seconds field.
    q_seconds = 6'd0;
    step(1, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1);
      step(0, 1, 0);
    end
    step(0, 0, 0);
`ifdef AUTO_REPEAT_EN
    exp6 = 6;
`else
    exp6 = 1;
`endif
    step(1, 0, 0);
    chk("t6_addr", addrs, 0); chk("t6_hold_inc", data_in, exp6);
    step(0, 0, 0);

    // Randomized levels, ticks and counter values against the model.
    rm = 1'b0; ri = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(9) == 0) rm = ~rm;
      if ($urandom_range(5) == 0) ri = ~ri;
      if ($urandom_range(15) == 0) begin
        q_hours = 6'($urandom_range(63));
        q_minutes = 6'($urandom_range(63));
        q_seconds = 6'($urandom_range(63));
      end
      step(rm, ri, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
